// File: rtl/uart_rx.sv
// UART receive front-end: 2-flop synchronised rx, OVERSAMPLE ticks per bit, MSB-first frames.
// Good frames update data with a one-cycle load; a low stop bit raises a sticky error.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 load,
    output logic                 error
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    // Metastability guard; flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // Frame sequencer; samples land mid-bit, counted from the start-bit detection edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            data  <= '0;
            load  <= 1'b0;
            error <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= '0;
                        error <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxs) begin
                            idx   <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {shreg[DATA_BITS-2:0], rxs};
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            data  <= shreg;
                            load  <= 1'b1;
                            error <= 1'b0;
                            state <= IDLE;
                        end else begin
                            error <= 1'b1;
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Break or stuck-low line: only a return to high re-arms detection.
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

    localparam int unsigned OS = 16;
    localparam int unsigned DB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       load;
    logic       error;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    logic [7:0]  load_q[$];
    int unsigned load_t[$];
    logic        prev_load = 1'b0;

    logic [7:0]  m_data = 8'h00;
    logic        m_err  = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .data  (data),
        .load  (load),
        .error (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every load pulse; a pulse longer than one cycle is an error.
    always @(negedge clk) begin
        if (load) begin
            load_q.push_back(data);
            load_t.push_back(cyc);
            check("load_width", 32'(prev_load), 32'd0);
        end
        prev_load = load;
    end

    task automatic idle_bits(input int unsigned bits);
        rx = 1'b1;
        repeat (bits * OS) @(negedge clk);
    endtask

    // Drive one frame from a negedge; the model predicts the outcome from the stop bit alone.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        int unsigned t_fall;
        int unsigned lat;
        load_q.delete();
        load_t.delete();
        t_fall = cyc;
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        m_err = 1'b0;
        check("err_clr_on_start", 32'(error), 32'(m_err));
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            repeat (OS) @(negedge clk);
        end
        rx = stop;
        repeat (OS) @(negedge clk);
        if (stop) begin
            m_data = b;
            m_err  = 1'b0;
            check("load_count", 32'(load_q.size()), 32'd1);
            if (load_q.size() > 0) begin
                lat = load_t[0] - t_fall;
                check("load_data", 32'(load_q[0]), 32'(b));
                check("load_latency", lat, 32'd155);
            end
        end else begin
            m_err = 1'b1;
            check("no_load_bad_stop", 32'(load_q.size()), 32'd0);
        end
        check("data", 32'(data), 32'(m_data));
        check("error", 32'(error), 32'(m_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        // Reset held for two bit times with the line idle.
        for (int k = 0; k < 4; k++) begin
            repeat (OS / 2) @(negedge clk);
            check("rst_data", 32'(data), 32'd0);
            check("rst_load", 32'(load), 32'd0);
            check("rst_error", 32'(error), 32'd0);
        end
        reset = 1'b1;
        load_q.delete();
        idle_bits(2);
        check("idle_data", 32'(data), 32'd0);
        check("idle_error", 32'(error), 32'd0);
        check("idle_no_load", 32'(load_q.size()), 32'd0);

        send_frame(8'hAA, 1'b1);
        idle_bits(4);
        send_frame(8'h55, 1'b1);
        idle_bits(1);

        // Framing error with the line held low afterwards.
        send_frame(8'hAA, 1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat (OS) @(negedge clk);
            check("wait_error", 32'(error), 32'd1);
            check("wait_no_load", 32'(load_q.size()), 32'd0);
            check("wait_data", 32'(data), 32'h55);
        end
        idle_bits(2);
        check("error_sticky", 32'(error), 32'd1);
        send_frame(8'h81, 1'b1);
        idle_bits(1);

        // Short glitch: rejected at mid start bit.
        load_q.delete();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check("glitch_no_load", 32'(load_q.size()), 32'd0);
        check("glitch_error", 32'(error), 32'd0);
        check("glitch_data", 32'(data), 32'(m_data));

        // Reset in the middle of the data bits.
        load_q.delete();
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        rx = 1'b1; repeat (OS) @(negedge clk);
        rx = 1'b0; repeat (OS) @(negedge clk);
        rx = 1'b1; repeat (OS / 2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_load", 32'(load), 32'd0);
        reset  = 1'b1;
        m_data = 8'h00;
        m_err  = 1'b0;
        idle_bits(1);
        check("midrst_no_load", 32'(load_q.size()), 32'd0);
        send_frame(8'h3C, 1'b1);

        // Random frames, including back-to-back and framing errors.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            if (!stop) begin
                repeat ($urandom_range(0, 2) * OS) @(negedge clk);
                check("rand_err_hold", 32'(error), 32'd1);
                idle_bits($urandom_range(1, 2));
            end else begin
                idle_bits($urandom_range(0, 2));
            end
        end
        idle_bits(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
